// File: rtl/reg_file_wb_if.sv
// Writeback, issue, read-port and debug signals shared between the pipeline and the register file.
// Latency and backpressure are defined by reg_file_wb; this file only bundles the wires.
// master drives the i* signals; slave (the register file) drives the o* signals.
interface reg_file_wb_if #(
    parameter int XLEN = 32
);
    logic            iRegWrite;
    logic [4:0]      iRd;
    logic [XLEN-1:0] iRegDataIn;
    logic [4:0]      iRs1;
    logic [4:0]      iRs2;
    logic [XLEN-1:0] oRs1Data;
    logic [XLEN-1:0] oRs2Data;
    logic            iIssueValid;
    logic [4:0]      iIssueRd;
    logic            oRs1Busy;
    logic            oRs2Busy;
    logic [5:0]      oPendingCount;
    logic            iDbgReq;
    logic [4:0]      iDbgAddr;
    logic            oDbgValid;
    logic [XLEN-1:0] oDbgData;

    modport master (
        output iRegWrite, iRd, iRegDataIn, iRs1, iRs2, iIssueValid, iIssueRd, iDbgReq, iDbgAddr,
        input  oRs1Data, oRs2Data, oRs1Busy, oRs2Busy, oPendingCount, oDbgValid, oDbgData
    );

    modport slave (
        input  iRegWrite, iRd, iRegDataIn, iRs1, iRs2, iIssueValid, iIssueRd, iDbgReq, iDbgAddr,
        output oRs1Data, oRs2Data, oRs1Busy, oRs2Busy, oPendingCount, oDbgValid, oDbgData
    );
endinterface

// File: rtl/reg_file_wb.sv
// 32-entry register file with pending-writer scoreboard and debug read port (REGFILE_WB_BYPASS_EN adds write->read bypass).
// Latency: reads/busy combinational; writes, pending count and debug response registered (1 cycle).
// Backpressure: none; every write, issue and debug request is accepted each cycle outside reset.
module reg_file_wb #(
    parameter int XLEN = 32
) (
    input  logic         iClk,
    input  logic         iRstN,
    reg_file_wb_if.slave bus
);
    localparam int NREG = 32;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            dbg_vld_q, dbg_vld_d;
    logic [XLEN-1:0] dbg_dat_q, dbg_dat_d;

    logic wr_en, iss_en, set_new, clr_old;

    assign wr_en  = bus.iRegWrite && (bus.iRd != 5'd0);
    assign iss_en = bus.iIssueValid && (bus.iIssueRd != 5'd0);

    // Count only real bit transitions; a same-register issue suppresses the clear.
    assign set_new = iss_en && !pend_q[bus.iIssueRd];
    assign clr_old = wr_en && pend_q[bus.iRd] && !(iss_en && (bus.iIssueRd == bus.iRd));

    always_comb begin
        regs_d    = regs_q;
        pend_d    = pend_q;
        dbg_vld_d = bus.iDbgReq;
        dbg_dat_d = dbg_dat_q;
        if (wr_en) begin
            regs_d[bus.iRd] = bus.iRegDataIn;
            pend_d[bus.iRd] = 1'b0;
        end
        if (iss_en) begin
            pend_d[bus.iIssueRd] = 1'b1;
        end
        pend_d[0] = 1'b0;
        cnt_d = cnt_q + 6'(set_new) - 6'(clr_old);
        if (bus.iDbgReq) begin
            dbg_dat_d = (bus.iDbgAddr == 5'd0) ? '0 : regs_q[bus.iDbgAddr];
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q    <= '0;
            cnt_q     <= '0;
            dbg_vld_q <= 1'b0;
            dbg_dat_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            dbg_vld_q <= dbg_vld_d;
            dbg_dat_q <= dbg_dat_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        logic [XLEN-1:0] val;
        val = regs_q[addr];
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_en && (bus.iRd == addr)) begin
            val = bus.iRegDataIn;
        end
`endif
        if (addr == 5'd0) begin
            val = '0;
        end
        return val;
    endfunction

    function automatic logic busy_port(input logic [4:0] addr);
        logic busy;
        busy = pend_q[addr];
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_en && (bus.iRd == addr) && !(iss_en && (bus.iIssueRd == addr))) begin
            busy = 1'b0;
        end
`endif
        return busy;
    endfunction

    always_comb begin
        bus.oRs1Data = read_port(bus.iRs1);
        bus.oRs2Data = read_port(bus.iRs2);
        bus.oRs1Busy = busy_port(bus.iRs1);
        bus.oRs2Busy = busy_port(bus.iRs2);
    end

    assign bus.oPendingCount = cnt_q;
    assign bus.oDbgValid     = dbg_vld_q;
    assign bus.oDbgData      = dbg_dat_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and random stimulus for reg_file_wb against an array/scoreboard model of the register file.
module tb_reg_file_wb;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    reg_file_wb_if #(.XLEN(32)) bus();
    reg_file_wb #(.XLEN(32)) dut (.iClk(clk), .iRstN(rstn), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic        m_dv;
    logic [31:0] m_dd;

    logic [31:0] c_rs1, c_rs2;
    logic        c_b1, c_b2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit we, input logic [4:0] rd,
                                             input logic [31:0] wd);
        if (a == 0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
        if (we && rd != 0 && rd == a) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit we, input logic [4:0] rd,
                                      input bit iv, input logic [4:0] ird);
`ifdef REGFILE_WB_BYPASS_EN
        if (we && rd != 0 && rd == a && !(iv && ird == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic logic [31:0] model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return 32'(n);
    endfunction

    // One clock: drive, check combinational outputs, advance the model at the edge, check registered outputs.
    task automatic cyc(input bit rn, input bit we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit iv, input logic [4:0] ird,
                       input bit dq, input logic [4:0] da);
        rstn = rn;
        bus.iRegWrite = we;   bus.iRd = rd;         bus.iRegDataIn = wd;
        bus.iRs1 = rs1;       bus.iRs2 = rs2;
        bus.iIssueValid = iv; bus.iIssueRd = ird;
        bus.iDbgReq = dq;     bus.iDbgAddr = da;
        #2;
        c_rs1 = bus.oRs1Data; c_rs2 = bus.oRs2Data;
        c_b1  = bus.oRs1Busy; c_b2  = bus.oRs2Busy;
        chk("rs1_data", c_rs1, exp_read(rs1, we, rd, wd));
        chk("rs2_data", c_rs2, exp_read(rs2, we, rd, wd));
        chk("rs1_busy", 32'(c_b1), 32'(exp_busy(rs1, we, rd, iv, ird)));
        chk("rs2_busy", 32'(c_b2), 32'(exp_busy(rs2, we, rd, iv, ird)));
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
            m_dv = 1'b0; m_dd = 32'h0;
        end else begin
            m_dv = dq;
            if (dq) m_dd = (da == 0) ? 32'h0 : m_regs[da];
            if (we && rd != 0) begin m_regs[rd] = wd; m_pend[rd] = 1'b0; end
            if (iv && ird != 0) m_pend[ird] = 1'b1;
        end
        #1;
        chk("pend_count", 32'(bus.oPendingCount), model_count());
        chk("dbg_valid", 32'(bus.oDbgValid), 32'(m_dv));
        chk("dbg_data", bus.oDbgData, m_dd);
    endtask

    initial begin
        rstn = 1'b0;
        bus.iRegWrite = 1'b1; bus.iRd = 5'd1; bus.iRegDataIn = 32'hFFFF_FFFF;
        bus.iRs1 = 5'd1; bus.iRs2 = 5'd0;
        bus.iIssueValid = 1'b1; bus.iIssueRd = 5'd2;
        bus.iDbgReq = 1'b1; bus.iDbgAddr = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_pend[i] = 1'b0; end
        m_dv = 1'b0; m_dd = 32'h0;
        chk("reset_count", 32'(bus.oPendingCount), 32'd0);
        chk("reset_dbg_valid", 32'(bus.oDbgValid), 32'd0);
        chk("reset_dbg_data", bus.oDbgData, 32'd0);
        chk("reset_x1", bus.oRs1Data, 32'd0);
        chk("reset_x2_busy", 32'(bus.oRs2Busy), 32'd0);

        // Write x5, read back; x0 ignores writes.
        cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 32'h1234, 5, 0, 0, 0, 0, 0);
        chk("x5_read", c_rs1, 32'hDEADBEEF);
        chk("x0_read_same", c_rs2, 32'h0);
        cyc(1, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        chk("x0_read_after", c_rs2, 32'h0);

        // Same-cycle write/read of x7.
        cyc(1, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 32'h22, 7, 0, 0, 0, 0, 0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("x7_same_cycle", c_rs1, 32'h22);
`else
        chk("x7_same_cycle", c_rs1, 32'h11);
`endif
        cyc(1, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        chk("x7_next_cycle", c_rs1, 32'h22);

        // Scoreboard: issue, retire, and issue+retire collision.
        cyc(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        chk("count_after_i3", 32'(bus.oPendingCount), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        chk("count_after_i4", 32'(bus.oPendingCount), 32'd2);
        cyc(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        chk("x3_busy", 32'(c_b1), 32'd1);
        cyc(1, 1, 3, 32'h33, 3, 0, 0, 0, 0, 0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("x3_busy_wb_cycle", 32'(c_b1), 32'd0);
`else
        chk("x3_busy_wb_cycle", 32'(c_b1), 32'd1);
`endif
        chk("count_after_wb3", 32'(bus.oPendingCount), 32'd1);
        cyc(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        chk("x3_busy_cleared", 32'(c_b1), 32'd0);
        cyc(1, 1, 4, 32'h44, 0, 0, 1, 4, 0, 0);
        chk("count_issue_wb_same", 32'(bus.oPendingCount), 32'd1);
        cyc(1, 0, 0, 0, 4, 0, 0, 0, 0, 0);
        chk("x4_still_busy", 32'(c_b1), 32'd1);

        // Debug reads: pre-write value, then back-to-back responses, then hold.
        cyc(1, 1, 9, 32'h5A, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 9, 32'hA5, 0, 0, 0, 0, 1, 9);
        chk("dbg_old_valid", 32'(bus.oDbgValid), 32'd1);
        chk("dbg_old_data", bus.oDbgData, 32'h5A);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("dbg_b2b_1", 32'(bus.oDbgValid), 32'd1);
        chk("dbg_x0", bus.oDbgData, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        chk("dbg_b2b_2", 32'(bus.oDbgValid), 32'd1);
        chk("dbg_x5", bus.oDbgData, 32'hDEADBEEF);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        chk("dbg_b2b_3", 32'(bus.oDbgValid), 32'd1);
        chk("dbg_x9", bus.oDbgData, 32'hA5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        chk("dbg_idle_valid", 32'(bus.oDbgValid), 32'd0);
        chk("dbg_idle_hold", bus.oDbgData, 32'hA5);

        // Reset mid-flight with concurrent write/issue/debug.
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        chk("count_before_rst", 32'(bus.oPendingCount), 32'd4);
        cyc(0, 1, 1, 32'hFF, 0, 0, 1, 5, 1, 9);
        chk("rst_count", 32'(bus.oPendingCount), 32'd0);
        chk("rst_dbg_valid", 32'(bus.oDbgValid), 32'd0);
        cyc(1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        chk("rst_x1_data", c_rs1, 32'h0);
        chk("rst_x1_busy", 32'(c_b1), 32'd0);
        chk("rst_x2_busy", 32'(c_b2), 32'd0);
        cyc(1, 0, 0, 0, 3, 4, 0, 0, 0, 0);
        chk("rst_x3_busy", 32'(c_b1), 32'd0);
        chk("rst_x4_busy", 32'(c_b2), 32'd0);

        // Random traffic on a narrow register window to force collisions.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
